// File: rtl/sliced_logic_unit_pkg.sv
// Shared types for the sliced bitwise logic unit.
// Holds the operation encoding and the controller state encoding.
package logic_unit_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } logic_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/sliced_logic_unit_if.sv
// Request/response bundle of the sliced logic unit.
// master: start, op, a, b out; busy, done, result, zero in. slave: mirrored.
interface sliced_logic_unit_if
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32
);

    logic             start;
    logic_op_t        op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, zero
    );

endinterface

// File: rtl/sliced_logic_unit_slice_logic.sv
// Combinational bitwise operator for one SLICE-bit slice.
// Ports: y = f(op, a, b); a, b slice operands; op selects AND/OR/XOR/NOR.
module slice_logic
    import logic_unit_pkg::*;
#(
    parameter int SLICE = 8
) (
    output logic [SLICE-1:0] y,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic_op_t        op
);

    wire [SLICE-1:0] y_and;
    wire [SLICE-1:0] y_or;
    wire [SLICE-1:0] y_xor;
    wire [SLICE-1:0] y_nor;

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        and u_and (y_and[i], a[i], b[i]);
        or  u_or  (y_or[i],  a[i], b[i]);
        xor u_xor (y_xor[i], a[i], b[i]);
        nor u_nor (y_nor[i], a[i], b[i]);
    end

    always_comb begin
        y = '0;
        unique case (op)
            OP_AND: y = y_and;
            OP_OR:  y = y_or;
            OP_XOR: y = y_xor;
            OP_NOR: y = y_nor;
        endcase
    end

endmodule

// File: rtl/sliced_logic_unit.sv
// Multi-cycle bitwise logic unit: SLICE bits per clock, LSB slice first.
// Ports: clk, reset (sync, active-high); bus = start/op/a/b in, busy/done/result/zero out.
module sliced_logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input logic               clk,
    input logic               reset,
    sliced_logic_unit_if.slave bus
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_slice
        $fatal(1, "sliced_logic_unit: WIDTH must be a multiple of SLICE");
    end

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic_op_t        op_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;

    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] y_sl;
    logic [WIDTH-1:0] result_d;

    assign a_sl = a_q[int'(cnt_q) * SLICE +: SLICE];
    assign b_sl = b_q[int'(cnt_q) * SLICE +: SLICE];

    slice_logic #(
        .SLICE (SLICE)
    ) u_slice (
        .y  (y_sl),
        .a  (a_sl),
        .b  (b_sl),
        .op (op_q)
    );

    // Result with the current slice merged in; the zero flag is
    // taken from this so it reflects the final slice too.
    always_comb begin
        result_d = result_q;
        result_d[int'(cnt_q) * SLICE +: SLICE] = y_sl;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_AND;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        op_q     <= bus.op;
                        result_q <= '0;
                        zero_q   <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= BUSY;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    result_q <= result_d;
                    if (cnt_q == LAST) begin
                        zero_q  <= (result_d == '0);
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy   = (state_q == BUSY);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.zero   = zero_q;

endmodule

// File: tb/tb_sliced_logic_unit.sv
// Directed bench for sliced_logic_unit: vector table plus timing sequences.
// Instances: 32/8 (main) and 32/32 (single-slice).
module tb_sliced_logic_unit;
    import logic_unit_pkg::*;

    typedef struct {
        logic_op_t   op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    vec_t vecs[10];

    always #5 clk = ~clk;

    sliced_logic_unit_if #(.WIDTH(32)) b8 ();
    sliced_logic_unit_if #(.WIDTH(32)) b1 ();

    sliced_logic_unit #(
        .WIDTH (32),
        .SLICE (8)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b8)
    );

    sliced_logic_unit #(
        .WIDTH (32),
        .SLICE (32)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        int bcnt;
        @(negedge clk);
        b8.start = 1'b1;
        b8.op    = v.op;
        b8.a     = v.a;
        b8.b     = v.b;
        @(posedge clk);
        @(negedge clk);
        // scramble inputs: the unit must use its latched copies
        b8.start = 1'b0;
        b8.op    = OP_OR;
        b8.a     = ~v.a;
        b8.b     = $urandom;
        lat  = 1;
        bcnt = 0;
        while (!b8.done && lat < 20) begin
            if (b8.busy) bcnt++;
            if (lat == 2)
                check($sformatf("v%0d partial", idx), b8.result,
                      v.res & 32'h0000_00FF);
            @(negedge clk);
            lat++;
        end
        check($sformatf("v%0d latency", idx), lat, 5);
        check($sformatf("v%0d busy_cycles", idx), bcnt, 4);
        check($sformatf("v%0d result", idx), b8.result, v.res);
        check($sformatf("v%0d zero", idx), {31'b0, b8.zero}, {31'b0, v.zero});
        @(negedge clk);
        check($sformatf("v%0d done_pulse", idx), {31'b0, b8.done}, 32'd0);
        check($sformatf("v%0d held", idx), b8.result, v.res);
    endtask

    initial begin
        int lat;
        int pulses;
        logic [31:0] got;

        vecs[0] = '{OP_XOR, 32'h1FF8_0000, 32'h0080_0000, 32'h1F78_0000, 1'b0};
        vecs[1] = '{OP_AND, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 1'b0};
        vecs[2] = '{OP_NOR, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[3] = '{OP_XOR, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
        vecs[4] = '{OP_OR,  32'h1234_5678, 32'h8765_4321, 32'h9775_5779, 1'b0};
        vecs[5] = '{OP_AND, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[6] = '{OP_NOR, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[7] = '{OP_XOR, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 1'b0};
        vecs[8] = '{OP_NOR, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'hF000_F000, 1'b0};
        vecs[9] = '{OP_OR,  32'h0000_0001, 32'h8000_0000, 32'h8000_0001, 1'b0};

        b8.start = 1'b0; b8.op = OP_AND; b8.a = '0; b8.b = '0;
        b1.start = 1'b0; b1.op = OP_AND; b1.a = '0; b1.b = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst busy",   {31'b0, b8.busy}, 32'd0);
        check("rst done",   {31'b0, b8.done}, 32'd0);
        check("rst result", b8.result, 32'd0);
        check("rst zero",   {31'b0, b8.zero}, 32'd0);
        check("rst1 result", b1.result, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // start during BUSY is ignored; operand changes have no effect
        @(negedge clk);
        b8.start = 1'b1; b8.op = OP_XOR;
        b8.a = 32'h1FF8_0000; b8.b = 32'h0080_0000;
        @(posedge clk);
        @(negedge clk);
        b8.start = 1'b0;
        @(negedge clk);
        b8.start = 1'b1; b8.op = OP_OR;
        b8.a = 32'h0000_FFFF; b8.b = 32'h1234_0000;
        @(negedge clk);
        b8.start = 1'b0;
        b8.a = 32'hFFFF_FFFF; b8.b = 32'h0;
        pulses = 0;
        got = '0;
        lat = 3;
        for (int k = 0; k < 12; k++) begin
            if (b8.done) begin
                pulses++;
                got = b8.result;
                if (pulses == 1) check("ign latency", lat, 5);
            end
            @(negedge clk);
            lat++;
        end
        check("ign pulses", pulses, 1);
        check("ign result", got, 32'h1F78_0000);

        // back-to-back: start held during DONE
        @(negedge clk);
        b8.start = 1'b1; b8.op = OP_XOR;
        b8.a = 32'h1FF8_0000; b8.b = 32'h0080_0000;
        @(posedge clk);
        @(negedge clk);
        b8.start = 1'b0;
        lat = 1;
        while (!b8.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("b2b first", b8.result, 32'h1F78_0000);
        b8.start = 1'b1; b8.op = OP_AND;
        b8.a = 32'hFFFF_0000; b8.b = 32'h0F0F_0F0F;
        @(posedge clk);
        @(negedge clk);
        b8.start = 1'b0;
        check("b2b restart busy", {31'b0, b8.busy}, 32'd1);
        lat = 1;
        while (!b8.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("b2b latency", lat, 5);
        check("b2b result", b8.result, 32'h0F0F_0000);
        check("b2b zero", {31'b0, b8.zero}, 32'd0);

        // reset mid-BUSY abandons the operation
        @(negedge clk);
        b8.start = 1'b1; b8.op = OP_NOR;
        b8.a = 32'h0; b8.b = 32'h0;
        @(posedge clk);
        @(negedge clk);
        b8.start = 1'b0;
        @(negedge clk);
        check("pre-rst partial", b8.result, 32'h0000_00FF);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("mid-rst busy",   {31'b0, b8.busy}, 32'd0);
        check("mid-rst result", b8.result, 32'd0);
        check("mid-rst zero",   {31'b0, b8.zero}, 32'd0);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            if (b8.done) pulses++;
            @(negedge clk);
        end
        check("mid-rst no done", pulses, 0);

        // single-slice instance
        @(negedge clk);
        b1.start = 1'b1; b1.op = OP_OR;
        b1.a = 32'h0000_1000; b1.b = 32'h0000_0004;
        @(posedge clk);
        @(negedge clk);
        b1.start = 1'b0;
        b1.a = 32'h0;
        check("n1 busy", {31'b0, b1.busy}, 32'd1);
        lat = 1;
        while (!b1.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("n1 latency", lat, 2);
        check("n1 result", b1.result, 32'h0000_1004);
        check("n1 zero", {31'b0, b1.zero}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
